// File: rtl/onchip_dpram_avalon.sv
// Dual-port Avalon-MM on-chip RAM with byte lanes, configurable read latency and a
// zero-fill clear engine. Define ONCHIP_RDW_FWD_EN to forward mixed-port read-during-write data.
module onchip_dpram_avalon #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2048,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                clear_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we;
    logic              wait_all;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] addr  [2];
    logic [BE_W-1:0]   be    [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] rdata [2];
    logic [1:0]        cs, rd, wr;
    logic [1:0]        rd_acc, wr_en, in_range, rvalid;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;
    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};

    // Reset parks the FSM at the start of the clear phase so release begins counting at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wait_all         = reset | (state_q == ST_CLEAR);
    assign clear_busy       = (state_q == ST_CLEAR) | (reset & (CLEAR_ON_RESET != 0));
    assign s1_waitrequest   = wait_all;
    assign s2_waitrequest   = wait_all;

    // s2 lanes are written first so s1 overrides them on a same-address collision.
    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int l = 0; l < BE_W; l++) begin
                if (wr_en[1] && be[1][l]) mem_q[addr[1]][l*8 +: 8] <= wdata[1][l*8 +: 8];
                if (wr_en[0] && be[0][l]) mem_q[addr[0]][l*8 +: 8] <= wdata[0][l*8 +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] ram_q;
            logic              oor_q;
            logic              v1_q;
            logic [DATA_W-1:0] word1;

            assign in_range[gi] = {1'b0, addr[gi]} < DEPTH_V;
            assign rd_acc[gi]   = cs[gi] & rd[gi] & ~wr[gi] & ~wait_all;
            assign wr_en[gi]    = cs[gi] & wr[gi] & ~wait_all & in_range[gi];

            // Read capture only moves on an accepted read, so readdata holds between pulses.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ram_q <= '0;
                    oor_q <= 1'b0;
                    v1_q  <= 1'b0;
                end else begin
                    v1_q <= rd_acc[gi];
                    if (rd_acc[gi]) begin
                        ram_q <= mem_q[addr[gi]];
                        oor_q <= ~in_range[gi];
                    end
                end
            end

`ifdef ONCHIP_RDW_FWD_EN
            localparam int OTHER = 1 - gi;
            logic [BE_W-1:0]   fwd_be_q;
            logic [DATA_W-1:0] fwd_wd_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    fwd_be_q <= '0;
                    fwd_wd_q <= '0;
                end else if (rd_acc[gi]) begin
                    fwd_be_q <= (wr_en[OTHER] && (addr[OTHER] == addr[gi])) ? be[OTHER] : '0;
                    fwd_wd_q <= wdata[OTHER];
                end
            end

            always_comb begin
                word1 = ram_q;
                for (int l = 0; l < BE_W; l++) begin
                    if (fwd_be_q[l]) word1[l*8 +: 8] = fwd_wd_q[l*8 +: 8];
                end
                if (oor_q) word1 = '0;
            end
`else
            assign word1 = oor_q ? '0 : ram_q;
`endif

            if (RD_LAT == 2) begin : g_lat2
                logic [DATA_W-1:0] out_q;
                logic              v2_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        out_q <= '0;
                        v2_q  <= 1'b0;
                    end else begin
                        v2_q <= v1_q;
                        if (v1_q) out_q <= word1;
                    end
                end

                assign rdata[gi]  = out_q;
                assign rvalid[gi] = v2_q;
            end else begin : g_lat1
                assign rdata[gi]  = word1;
                assign rvalid[gi] = v1_q;
            end
        end
    endgenerate

    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdatavalid = rvalid[1];

endmodule

// File: tb/tb_onchip_dpram_avalon.sv
// Bench for onchip_dpram_avalon: two instances (RD_LAT 1 and 2) share one stimulus stream and
// are checked against a word-array model with due-time read queues.
module tb_onchip_dpram_avalon;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [AW-1:0] s1_address = '0, s2_address = '0;
    logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
    logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic          s1_read = 1'b0, s2_read = 1'b0;
    logic          s1_write = 1'b0, s2_write = 1'b0;
    logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;

    wire [3:0][DW-1:0] rdata_w;
    wire [3:0]         rvalid_w;
    wire [3:0]         wait_w;
    wire [1:0]         busy_w;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            onchip_dpram_avalon #(
                .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(gi + 1), .CLEAR_ON_RESET(1)
            ) u_dut (
                .clk(clk), .reset(reset),
                .s1_address(s1_address), .s1_byteenable(s1_byteenable),
                .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
                .s1_writedata(s1_writedata), .s1_readdata(rdata_w[gi*2]),
                .s1_readdatavalid(rvalid_w[gi*2]), .s1_waitrequest(wait_w[gi*2]),
                .s2_address(s2_address), .s2_byteenable(s2_byteenable),
                .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
                .s2_writedata(s2_writedata), .s2_readdata(rdata_w[gi*2+1]),
                .s2_readdatavalid(rvalid_w[gi*2+1]), .s2_waitrequest(wait_w[gi*2+1]),
                .clear_busy(busy_w[gi])
            );
        end
    endgenerate

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          clear_left = DEPTH;
    bit          rst_cur   = 1'b1;
    logic [31:0] mdl_mem [DEPTH];
    exp_t        expq [4][$];
    logic [31:0] last_d [4] = '{default: 32'h0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("L%0d clear_busy", d + 1), 32'(busy_w[d]), 32'(clear_left > 0 || rst_cur));
            for (int p = 0; p < 2; p++) begin
                int k;
                bit ev;
                k  = d * 2 + p;
                ev = (expq[k].size() > 0) && (expq[k][0].due == cyc);
                chk($sformatf("L%0d s%0d waitrequest", d + 1, p + 1), 32'(wait_w[k]),
                    32'(rst_cur || clear_left > 0));
                chk($sformatf("L%0d s%0d readdatavalid", d + 1, p + 1), 32'(rvalid_w[k]), 32'(ev));
                if (ev) begin
                    chk($sformatf("L%0d s%0d readdata", d + 1, p + 1), rdata_w[k], expq[k][0].data);
                    last_d[k] = expq[k][0].data;
                    void'(expq[k].pop_front());
                end else begin
                    chk($sformatf("L%0d s%0d readdata hold", d + 1, p + 1), rdata_w[k], last_d[k]);
                end
            end
        end
    endtask

    // One bus cycle: check what the previous edge produced, drive new requests, advance the model.
    task automatic tick(input bit rst,
                        input bit c1, input bit r1, input bit w1, input logic [3:0] a1,
                        input logic [3:0] be1, input logic [31:0] d1,
                        input bit c2, input bit r2, input bit w2, input logic [3:0] a2,
                        input logic [3:0] be2, input logic [31:0] d2);
        logic [3:0]  a  [2];
        logic [3:0]  be [2];
        logic [31:0] d  [2];
        bit          c [2], r [2], w [2], inr [2], wacc [2], racc [2];
        @(negedge clk);
        cyc++;
        check_outputs();
        reset = rst;
        s1_chipselect = c1; s1_read = r1; s1_write = w1; s1_address = a1;
        s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = c2; s2_read = r2; s2_write = w2; s2_address = a2;
        s2_byteenable = be2; s2_writedata = d2;
        rst_cur = rst;
        a[0] = a1; be[0] = be1; d[0] = d1; c[0] = c1; r[0] = r1; w[0] = w1;
        a[1] = a2; be[1] = be2; d[1] = d2; c[1] = c2; r[1] = r2; w[1] = w2;
        if (rst) begin
            clear_left = DEPTH;
            for (int k = 0; k < 4; k++) begin
                expq[k].delete();
                last_d[k] = 32'h0;
            end
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                inr[p]  = int'(a[p]) < DEPTH;
                wacc[p] = c[p] && w[p] && inr[p];
                racc[p] = c[p] && r[p] && !w[p];
                if (c[p] && w[p])
                    $display("txn cyc=%0d s%0d WR a=%0d be=%h d=%h", cyc, p + 1, a[p], be[p], d[p]);
            end
            for (int p = 0; p < 2; p++) begin
                if (racc[p]) begin
                    logic [31:0] v;
                    v = inr[p] ? mdl_mem[a[p]] : 32'h0;
`ifdef ONCHIP_RDW_FWD_EN
                    if (wacc[1-p] && a[1-p] == a[p]) begin
                        for (int l = 0; l < 4; l++)
                            if (be[1-p][l]) v[l*8 +: 8] = d[1-p][l*8 +: 8];
                    end
`endif
                    $display("txn cyc=%0d s%0d RD a=%0d exp=%h", cyc, p + 1, a[p], v);
                    for (int dd = 0; dd < 2; dd++) expq[dd*2+p].push_back('{due: cyc + dd + 1, data: v});
                end
            end
            for (int l = 0; l < 4; l++) begin
                if (wacc[1] && be[1][l]) mdl_mem[a[1]][l*8 +: 8] = d[1][l*8 +: 8];
                if (wacc[0] && be[0][l]) mdl_mem[a[0]][l*8 +: 8] = d[0][l*8 +: 8];
            end
        end
    endtask

    task automatic idle(input int n, input bit rst);
        for (int i = 0; i < n; i++) tick(rst, 0,0,0,4'd0,4'd0,32'h0, 0,0,0,4'd0,4'd0,32'h0);
    endtask

    task automatic s1w(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        tick(0, 1,0,1,a,be,d, 0,0,0,4'd0,4'd0,32'h0);
    endtask

    task automatic s1r(input logic [3:0] a);
        tick(0, 1,1,0,a,4'hF,32'h0, 0,0,0,4'd0,4'd0,32'h0);
    endtask

    task automatic s2r(input logic [3:0] a);
        tick(0, 0,0,0,4'd0,4'd0,32'h0, 1,1,0,a,4'hF,32'h0);
    endtask

    initial begin
        logic [3:0] stream [8];
        stream[0] = 4'd0; stream[1] = 4'd5; stream[2] = 4'd13; stream[3] = 4'd3;
        stream[4] = 4'd7; stream[5] = 4'd11; stream[6] = 4'd12; stream[7] = 4'd2;

        // Clear sequence after reset release, then every address through both ports.
        idle(3, 1);
        idle(DEPTH + 2, 0);
        for (int i = 0; i < 16; i++)
            tick(0, 1,1,0,4'(i),4'hF,32'h0, 1,1,0,4'(15 - i),4'hF,32'h0);
        idle(3, 0);

        // Byte-lane merge, then collision with s1 priority on lane 0.
        s1w(4'd5, 4'hF, 32'hAABBCCDD);
        s1w(4'd5, 4'h5, 32'h11223344);
        s2r(4'd5);
        tick(0, 1,0,1,4'd3,4'h1,32'h000000FF, 1,0,1,4'd3,4'hF,32'h12345678);
        s1r(4'd3);
        idle(3, 0);

        // Mixed-port read-during-write in both directions, same-port write-then-read.
        s1w(4'd7, 4'hF, 32'h0);
        tick(0, 1,0,1,4'd7,4'hF,32'hDEADBEEF, 1,1,0,4'd7,4'hF,32'h0);
        s2r(4'd7);
        tick(0, 1,1,0,4'd9,4'hF,32'h0, 1,0,1,4'd9,4'h6,32'h5A5A5A5A);
        s1w(4'd4, 4'hF, 32'h01020304);
        s1r(4'd4);
        tick(0, 1,1,1,4'd6,4'hF,32'h66666666, 0,0,0,4'd0,4'd0,32'h0);
        s1w(4'd8, 4'h0, 32'hFFFFFFFF);
        s2r(4'd6);
        s2r(4'd8);
        idle(3, 0);

        // Streaming reads with an out-of-range address, then a discarded out-of-range write.
        for (int i = 0; i < 8; i++) s1r(stream[i]);
        s1w(4'd13, 4'hF, 32'hCAFEF00D);
        for (int i = 0; i < 16; i++) s1r(4'(i));
        idle(3, 0);

        // Reset with reads in flight, then reset in the middle of the clear phase.
        tick(0, 1,1,0,4'd5,4'hF,32'h0, 1,1,0,4'd3,4'hF,32'h0);
        tick(0, 1,1,0,4'd3,4'hF,32'h0, 1,1,0,4'd5,4'hF,32'h0);
        idle(2, 1);
        idle(9, 0);
        idle(1, 1);
        idle(DEPTH + 2, 0);

        // Randomized traffic; narrow address windows provoke collisions and read-during-write.
        for (int i = 0; i < 600; i++) begin
            bit          c1, r1, w1, c2, r2, w2, rst;
            logic [3:0]  a1, a2;
            int          hi;
            hi  = ($urandom_range(0, 3) == 0) ? 3 : 15;
            rst = ($urandom_range(0, 199) == 0);
            c1 = $urandom_range(0, 9) != 0; r1 = $urandom_range(0, 1) != 0; w1 = $urandom_range(0, 2) == 0;
            c2 = $urandom_range(0, 9) != 0; r2 = $urandom_range(0, 1) != 0; w2 = $urandom_range(0, 2) == 0;
            a1 = 4'($urandom_range(0, hi));
            a2 = 4'($urandom_range(0, hi));
            tick(rst, c1,r1,w1,a1,4'($urandom),$urandom, c2,r2,w2,a2,4'($urandom),$urandom);
        end
        idle(DEPTH + 4, 0);
        for (int i = 0; i < 16; i++)
            tick(0, 1,1,0,4'(i),4'hF,32'h0, 1,1,0,4'(i),4'hF,32'h0);
        idle(4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
